// File: rtl/note_recorder.sv
`timescale 1ns/1ps
// note_recorder: captures live key notes as (note, duration) events in a small
// event memory and replays them on demand. Durations are counted in ticks from
// a prescaler that restarts at each recorded event start and each replayed event load.
module note_recorder #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int DEPTH   = 64,
    parameter int DUR_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rec_btn,
    input  logic                   play_btn,
    input  logic                   clear_btn,
    input  logic [3:0]             note_in,
    output logic [3:0]             note_out,
    output logic [6:0]             led,
    output logic                   recording,
    output logic                   playing,
    output logic                   full,
    output logic [$clog2(DEPTH):0] event_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int PRESC   = CLK_HZ / TICK_HZ;
    localparam int PW      = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int ENTRY_W = 3 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_PLAY_RD,   // read address presented, memory output registers
        S_PLAY_LD,   // registered event is loaded into note_out / remaining
        S_PLAY_RUN   // event is sounding, remaining counts down per tick
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           note_out_q, note_out_d;
    logic [6:0]           led_q, led_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]           cur_note_q, cur_note_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [DUR_W-1:0]     rem_q, rem_d;
    logic [PW-1:0]        presc_q;
    logic                 presc_clr;
    logic                 mem_we;
    logic [ENTRY_W-1:0]   mem_wdata;
    logic [ENTRY_W-1:0]   rd_data_q;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic [2:0]           norm_in;
    logic [3:0]           live_note;
    logic                 tick;
    logic [DUR_W-1:0]     dur_eff;
    logic                 close_evt;
    logic                 last_evt;
    logic [2:0]           rd_note;
    logic [DUR_W-1:0]     rd_dur;

    // Values 8..15 carry no note and are folded onto rest (0).
    assign norm_in   = note_in[3] ? 3'd0 : note_in[2:0];
    assign live_note = {1'b0, norm_in};
    assign tick      = (presc_q == PW'(PRESC - 1));
    // Duration including a tick landing on this very clock, so a closing
    // event never loses its final tick. dur_q never exceeds DUR_MAX-1.
    assign dur_eff   = dur_q + DUR_W'(tick);
    assign close_evt = rec_btn || (norm_in != cur_note_q);
    assign last_evt  = (({1'b0, rd_ptr_q} + CW'(1)) == cnt_q);
    assign rd_note   = rd_data_q[ENTRY_W-1:DUR_W];
    assign rd_dur    = rd_data_q[DUR_W-1:0];

    function automatic logic [6:0] onehot_note(input logic [3:0] n);
        logic [6:0] r;
        r = 7'd0;
        if (n >= 4'd1 && n <= 4'd7) r = 7'b1 << (n - 4'd1);
        return r;
    endfunction

    // Next-state, event capture and playback sequencing.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        note_out_d = note_out_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        rem_d      = rem_q;
        presc_clr  = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = {cur_note_q, dur_eff};

        case (state_q)
            S_IDLE: begin
                note_out_d = live_note;
                if (rec_btn) begin
                    state_d    = S_RECORD;
                    cnt_d      = '0;
                    full_d     = 1'b0;
                    wr_ptr_d   = '0;
                    cur_note_d = norm_in;
                    dur_d      = '0;
                    presc_clr  = 1'b1;
                end else if (clear_btn) begin
                    cnt_d  = '0;
                    full_d = 1'b0;
                end else if (play_btn && (cnt_q != '0)) begin
                    state_d    = S_PLAY_RD;
                    rd_ptr_d   = '0;
                    note_out_d = 4'd0;
                end
            end

            S_RECORD: begin
                note_out_d = live_note;
                if (close_evt || (tick && (dur_eff == DUR_MAX))) begin
                    // Zero-length events are glitches and are dropped.
                    if (dur_eff != '0) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + CW'(1);
                        if (cnt_q == CW'(DEPTH - 1)) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    dur_d = '0;
                    // A saturated event continues as the same note without
                    // disturbing the prescaler phase.
                    if (close_evt) begin
                        cur_note_d = norm_in;
                        presc_clr  = 1'b1;
                    end
                    if (rec_btn) state_d = S_IDLE;
                end else if (tick) begin
                    dur_d = dur_eff;
                end
            end

            S_PLAY_RD: begin
                if (play_btn) begin
                    state_d    = S_IDLE;
                    note_out_d = live_note;
                end else begin
                    state_d = S_PLAY_LD;
                end
            end

            S_PLAY_LD: begin
                if (play_btn) begin
                    state_d    = S_IDLE;
                    note_out_d = live_note;
                end else begin
                    state_d    = S_PLAY_RUN;
                    note_out_d = {1'b0, rd_note};
                    rem_d      = rd_dur;
                    presc_clr  = 1'b1;
                end
            end

            S_PLAY_RUN: begin
                if (play_btn) begin
                    state_d    = S_IDLE;
                    note_out_d = live_note;
                end else if (tick) begin
                    if (rem_q == DUR_W'(1)) begin
                        if (last_evt) begin
                            state_d    = S_IDLE;
                            note_out_d = live_note;
                        end else begin
                            // Short silence while the next event is fetched.
                            state_d    = S_PLAY_RD;
                            rd_ptr_d   = rd_ptr_q + AW'(1);
                            note_out_d = 4'd0;
                        end
                        rem_d = '0;
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                note_out_d = live_note;
            end
        endcase

        led_d = onehot_note(note_out_d);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            note_out_q <= 4'd0;
            led_q      <= 7'd0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cur_note_q <= 3'd0;
            dur_q      <= '0;
            rem_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            note_out_q <= note_out_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cur_note_q <= cur_note_d;
            dur_q      <= dur_d;
            rem_q      <= rem_d;
        end
    end

    // Tick prescaler: free-running, restarted on event start/load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (presc_clr || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Event memory with one-clock synchronous read.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; event_count=0 makes stale contents unreachable.
        if (mem_we) mem[wr_ptr_q] <= mem_wdata;
        rd_data_q <= mem[rd_ptr_q];
    end

    assign note_out    = note_out_q;
    assign led         = led_q;
    assign recording   = (state_q == S_RECORD);
    assign playing     = (state_q == S_PLAY_RD) || (state_q == S_PLAY_LD) ||
                         (state_q == S_PLAY_RUN);
    assign full        = full_q;
    assign event_count = cnt_q;

endmodule
